// File: rtl/axi_xbar_1to2.sv
// axi_xbar_1to2
//   AXI4 1-to-2 address-decoding crossbar. The single upstream port (s_*) is
//   steered to the external SoC bus (m0_*) or the core-local CLINT (m1_*).
//   Each accepted AR/AW is registered and decoded. The following R, W and B
//   traffic is routed combinationally to the selected slave. The read and
//   write paths are independent and each has one transaction in flight.
//
//   Optional feature macro: XBAR_DECERR_EN
//     defined   - addresses outside both windows get a local DECERR response
//     undefined - every address outside the m1 window goes to m0
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   s_aw*/s_w*/s_b*/s_ar*/s_r*       upstream AXI4 slave port
//   m0_aw*/m0_w*/m0_b*/m0_ar*/m0_r*  master port toward the external bus
//   m1_aw*/m1_w*/m1_b*/m1_ar*/m1_r*  master port toward the CLINT
module axi_xbar_1to2 #(
  parameter logic [31:0] M0_BASE = 32'h0000_0000,
  parameter logic [31:0] M0_SIZE = 32'h0000_0000,
  parameter logic [31:0] M1_BASE = 32'h0200_0000,
  parameter logic [31:0] M1_SIZE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  // upstream AW / W / B
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [3:0]  s_awid,
  input  logic [7:0]  s_awlen,
  input  logic [2:0]  s_awsize,
  input  logic [1:0]  s_awburst,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  output logic [3:0]  s_bid,
  // upstream AR / R
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [1:0]  s_rresp,
  output logic [31:0] s_rdata,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  // m0 master port
  output logic        m0_awvalid,
  input  logic        m0_awready,
  output logic [31:0] m0_awaddr,
  output logic [3:0]  m0_awid,
  output logic [7:0]  m0_awlen,
  output logic [2:0]  m0_awsize,
  output logic [1:0]  m0_awburst,
  output logic        m0_wvalid,
  input  logic        m0_wready,
  output logic [31:0] m0_wdata,
  output logic [3:0]  m0_wstrb,
  output logic        m0_wlast,
  input  logic        m0_bvalid,
  output logic        m0_bready,
  input  logic [1:0]  m0_bresp,
  input  logic [3:0]  m0_bid,
  output logic        m0_arvalid,
  input  logic        m0_arready,
  output logic [31:0] m0_araddr,
  output logic [3:0]  m0_arid,
  output logic [7:0]  m0_arlen,
  output logic [2:0]  m0_arsize,
  output logic [1:0]  m0_arburst,
  input  logic        m0_rvalid,
  output logic        m0_rready,
  input  logic [1:0]  m0_rresp,
  input  logic [31:0] m0_rdata,
  input  logic        m0_rlast,
  input  logic [3:0]  m0_rid,
  // m1 master port
  output logic        m1_awvalid,
  input  logic        m1_awready,
  output logic [31:0] m1_awaddr,
  output logic [3:0]  m1_awid,
  output logic [7:0]  m1_awlen,
  output logic [2:0]  m1_awsize,
  output logic [1:0]  m1_awburst,
  output logic        m1_wvalid,
  input  logic        m1_wready,
  output logic [31:0] m1_wdata,
  output logic [3:0]  m1_wstrb,
  output logic        m1_wlast,
  input  logic        m1_bvalid,
  output logic        m1_bready,
  input  logic [1:0]  m1_bresp,
  input  logic [3:0]  m1_bid,
  output logic        m1_arvalid,
  input  logic        m1_arready,
  output logic [31:0] m1_araddr,
  output logic [3:0]  m1_arid,
  output logic [7:0]  m1_arlen,
  output logic [2:0]  m1_arsize,
  output logic [1:0]  m1_arburst,
  input  logic        m1_rvalid,
  output logic        m1_rready,
  input  logic [1:0]  m1_rresp,
  input  logic [31:0] m1_rdata,
  input  logic        m1_rlast,
  input  logic [3:0]  m1_rid
);

`ifdef XBAR_DECERR_EN
  typedef enum logic [1:0] {T_M0, T_M1, T_ERR} tgt_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rstate_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR, W_BERR} wstate_e;
`else
  typedef enum logic [1:0] {T_M0, T_M1} tgt_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
`endif

  // 33-bit compares so that base+size never wraps past 4 GiB.
  function automatic tgt_e decode(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr};
    if (a >= {1'b0, M1_BASE} && a < ({1'b0, M1_BASE} + {1'b0, M1_SIZE}))
      return T_M1;
`ifdef XBAR_DECERR_EN
    if (M0_SIZE == '0 ||
        (a >= {1'b0, M0_BASE} && a < ({1'b0, M0_BASE} + {1'b0, M0_SIZE})))
      return T_M0;
    return T_ERR;
`else
    return T_M0;
`endif
  endfunction

  // ---------------------------------------------------------------- read path
  rstate_e     r_rstate, w_rstate_nxt;
  tgt_e        r_rtgt, w_ar_tgt;
  logic [31:0] r_araddr;
  logic [3:0]  r_arid;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;
  logic        w_ar_hs;
  logic        w_m_arready, w_m_rvalid, w_m_rlast;
  logic [1:0]  w_m_rresp;
  logic [31:0] w_m_rdata;
  logic [3:0]  w_m_rid;

  assign w_ar_tgt    = decode(s_araddr);
  assign w_ar_hs     = (r_rstate == R_IDLE) && s_arvalid;
  assign w_m_arready = (r_rtgt == T_M1) ? m1_arready : m0_arready;
  assign w_m_rvalid  = (r_rtgt == T_M1) ? m1_rvalid  : m0_rvalid;
  assign w_m_rlast   = (r_rtgt == T_M1) ? m1_rlast   : m0_rlast;
  assign w_m_rresp   = (r_rtgt == T_M1) ? m1_rresp   : m0_rresp;
  assign w_m_rdata   = (r_rtgt == T_M1) ? m1_rdata   : m0_rdata;
  assign w_m_rid     = (r_rtgt == T_M1) ? m1_rid     : m0_rid;

  assign m0_araddr  = r_araddr;
  assign m0_arid    = r_arid;
  assign m0_arlen   = r_arlen;
  assign m0_arsize  = r_arsize;
  assign m0_arburst = r_arburst;
  assign m1_araddr  = r_araddr;
  assign m1_arid    = r_arid;
  assign m1_arlen   = r_arlen;
  assign m1_arsize  = r_arsize;
  assign m1_arburst = r_arburst;

  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rtgt    <= T_M0;
    end else if (w_ar_hs) begin
      r_araddr  <= s_araddr;
      r_arid    <= s_arid;
      r_arlen   <= s_arlen;
      r_arsize  <= s_arsize;
      r_arburst <= s_arburst;
      r_rtgt    <= w_ar_tgt;
    end
  end

`ifdef XBAR_DECERR_EN
  logic [7:0] r_rbeat;
  always_ff @(posedge clk) begin
    if (rst)                                 r_rbeat <= '0;
    else if (w_ar_hs)                        r_rbeat <= '0;
    else if (r_rstate == R_ERR && s_rready)  r_rbeat <= r_rbeat + 8'd1;
  end
`endif

  always_comb begin
    w_rstate_nxt = r_rstate;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    s_rresp      = '0;
    s_rdata      = '0;
    s_rlast      = 1'b0;
    s_rid        = '0;
    m0_arvalid   = 1'b0;
    m1_arvalid   = 1'b0;
    m0_rready    = 1'b0;
    m1_rready    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        // Held low during reset so ready rises only once rst is released.
        s_arready = !rst;
        if (s_arvalid) begin
`ifdef XBAR_DECERR_EN
          w_rstate_nxt = (w_ar_tgt == T_ERR) ? R_ERR : R_ADDR;
`else
          w_rstate_nxt = R_ADDR;
`endif
        end
      end
      R_ADDR: begin
        if (r_rtgt == T_M1) m1_arvalid = 1'b1;
        else                m0_arvalid = 1'b1;
        if (w_m_arready) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        s_rvalid = w_m_rvalid;
        s_rresp  = w_m_rresp;
        s_rdata  = w_m_rdata;
        s_rlast  = w_m_rlast;
        s_rid    = w_m_rid;
        if (r_rtgt == T_M1) m1_rready = s_rready;
        else                m0_rready = s_rready;
        if (w_m_rvalid && s_rready && w_m_rlast) w_rstate_nxt = R_IDLE;
      end
`ifdef XBAR_DECERR_EN
      R_ERR: begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
        s_rid    = r_arid;
        s_rlast  = (r_rbeat == r_arlen);
        if (s_rready && (r_rbeat == r_arlen)) w_rstate_nxt = R_IDLE;
      end
`endif
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------- write path
  wstate_e     r_wstate, w_wstate_nxt;
  tgt_e        r_wtgt, w_aw_tgt;
  logic [31:0] r_awaddr;
  logic [3:0]  r_awid;
  logic [7:0]  r_awlen;
  logic [2:0]  r_awsize;
  logic [1:0]  r_awburst;
  logic        w_aw_hs;
  logic        w_m_awready, w_m_wready, w_m_bvalid;
  logic [1:0]  w_m_bresp;
  logic [3:0]  w_m_bid;

  assign w_aw_tgt    = decode(s_awaddr);
  assign w_aw_hs     = (r_wstate == W_IDLE) && s_awvalid;
  assign w_m_awready = (r_wtgt == T_M1) ? m1_awready : m0_awready;
  assign w_m_wready  = (r_wtgt == T_M1) ? m1_wready  : m0_wready;
  assign w_m_bvalid  = (r_wtgt == T_M1) ? m1_bvalid  : m0_bvalid;
  assign w_m_bresp   = (r_wtgt == T_M1) ? m1_bresp   : m0_bresp;
  assign w_m_bid     = (r_wtgt == T_M1) ? m1_bid     : m0_bid;

  assign m0_awaddr  = r_awaddr;
  assign m0_awid    = r_awid;
  assign m0_awlen   = r_awlen;
  assign m0_awsize  = r_awsize;
  assign m0_awburst = r_awburst;
  assign m1_awaddr  = r_awaddr;
  assign m1_awid    = r_awid;
  assign m1_awlen   = r_awlen;
  assign m1_awsize  = r_awsize;
  assign m1_awburst = r_awburst;
  assign m0_wdata   = s_wdata;
  assign m0_wstrb   = s_wstrb;
  assign m0_wlast   = s_wlast;
  assign m1_wdata   = s_wdata;
  assign m1_wstrb   = s_wstrb;
  assign m1_wlast   = s_wlast;

  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
      r_wtgt    <= T_M0;
    end else if (w_aw_hs) begin
      r_awaddr  <= s_awaddr;
      r_awid    <= s_awid;
      r_awlen   <= s_awlen;
      r_awsize  <= s_awsize;
      r_awburst <= s_awburst;
      r_wtgt    <= w_aw_tgt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bresp      = '0;
    s_bid        = '0;
    m0_awvalid   = 1'b0;
    m1_awvalid   = 1'b0;
    m0_wvalid    = 1'b0;
    m1_wvalid    = 1'b0;
    m0_bready    = 1'b0;
    m1_bready    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        s_awready = !rst;
        if (s_awvalid) begin
`ifdef XBAR_DECERR_EN
          w_wstate_nxt = (w_aw_tgt == T_ERR) ? W_ERR : W_ADDR;
`else
          w_wstate_nxt = W_ADDR;
`endif
        end
      end
      W_ADDR: begin
        if (r_wtgt == T_M1) m1_awvalid = 1'b1;
        else                m0_awvalid = 1'b1;
        if (w_m_awready) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        s_wready = w_m_wready;
        if (r_wtgt == T_M1) m1_wvalid = s_wvalid;
        else                m0_wvalid = s_wvalid;
        if (s_wvalid && w_m_wready && s_wlast) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid = w_m_bvalid;
        s_bresp  = w_m_bresp;
        s_bid    = w_m_bid;
        if (r_wtgt == T_M1) m1_bready = s_bready;
        else                m0_bready = s_bready;
        if (w_m_bvalid && s_bready) w_wstate_nxt = W_IDLE;
      end
`ifdef XBAR_DECERR_EN
      W_ERR: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_wstate_nxt = W_BERR;
      end
      W_BERR: begin
        s_bvalid = 1'b1;
        s_bresp  = 2'b11;
        s_bid    = r_awid;
        if (s_bready) w_wstate_nxt = W_IDLE;
      end
`endif
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_xbar_1to2.sv
// Directed testbench for axi_xbar_1to2. The bench plays both downstream
// slaves by driving the m0_*/m1_* inputs directly, cycle by cycle.
module tb_axi_xbar_1to2;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready;  logic [31:0] s_awaddr;  logic [3:0] s_awid;
  logic [7:0]  s_awlen;  logic [2:0] s_awsize;  logic [1:0] s_awburst;
  logic        s_wvalid, s_wready;  logic [31:0] s_wdata;  logic [3:0] s_wstrb;  logic s_wlast;
  logic        s_bvalid, s_bready;  logic [1:0] s_bresp;  logic [3:0] s_bid;
  logic        s_arvalid, s_arready;  logic [31:0] s_araddr;  logic [3:0] s_arid;
  logic [7:0]  s_arlen;  logic [2:0] s_arsize;  logic [1:0] s_arburst;
  logic        s_rvalid, s_rready;  logic [1:0] s_rresp;  logic [31:0] s_rdata;
  logic        s_rlast;  logic [3:0] s_rid;

  logic        m0_awvalid, m0_awready;  logic [31:0] m0_awaddr;  logic [3:0] m0_awid;
  logic [7:0]  m0_awlen;  logic [2:0] m0_awsize;  logic [1:0] m0_awburst;
  logic        m0_wvalid, m0_wready;  logic [31:0] m0_wdata;  logic [3:0] m0_wstrb;  logic m0_wlast;
  logic        m0_bvalid, m0_bready;  logic [1:0] m0_bresp;  logic [3:0] m0_bid;
  logic        m0_arvalid, m0_arready;  logic [31:0] m0_araddr;  logic [3:0] m0_arid;
  logic [7:0]  m0_arlen;  logic [2:0] m0_arsize;  logic [1:0] m0_arburst;
  logic        m0_rvalid, m0_rready;  logic [1:0] m0_rresp;  logic [31:0] m0_rdata;
  logic        m0_rlast;  logic [3:0] m0_rid;

  logic        m1_awvalid, m1_awready;  logic [31:0] m1_awaddr;  logic [3:0] m1_awid;
  logic [7:0]  m1_awlen;  logic [2:0] m1_awsize;  logic [1:0] m1_awburst;
  logic        m1_wvalid, m1_wready;  logic [31:0] m1_wdata;  logic [3:0] m1_wstrb;  logic m1_wlast;
  logic        m1_bvalid, m1_bready;  logic [1:0] m1_bresp;  logic [3:0] m1_bid;
  logic        m1_arvalid, m1_arready;  logic [31:0] m1_araddr;  logic [3:0] m1_arid;
  logic [7:0]  m1_arlen;  logic [2:0] m1_arsize;  logic [1:0] m1_arburst;
  logic        m1_rvalid, m1_rready;  logic [1:0] m1_rresp;  logic [31:0] m1_rdata;
  logic        m1_rlast;  logic [3:0] m1_rid;

  int nvec = 0;
  int nerr = 0;
  int rb;

  always #5 clk = ~clk;

  axi_xbar_1to2 #(
    .M0_BASE(32'h8000_0000),
    .M0_SIZE(32'h1000_0000),
    .M1_BASE(32'h0200_0000),
    .M1_SIZE(32'h0001_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid),
    .m0_awlen(m0_awlen), .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_awvalid = 0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = 3'd2; s_awburst = 2'd1;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = 3'd2; s_arburst = 2'd1;
    s_rready = 0;
    m0_awready = 0; m0_wready = 0; m0_bvalid = 0; m0_bresp = '0; m0_bid = '0;
    m0_arready = 0; m0_rvalid = 0; m0_rresp = '0; m0_rdata = '0; m0_rlast = 0; m0_rid = '0;
    m1_awready = 0; m1_wready = 0; m1_bvalid = 0; m1_bresp = '0; m1_bid = '0;
    m1_arready = 0; m1_rvalid = 0; m1_rresp = '0; m1_rdata = '0; m1_rlast = 0; m1_rid = '0;

    // Reset state
    cyc(); cyc();
    chk("rst_m0_arvalid", m0_arvalid, 0);
    chk("rst_m1_awvalid", m1_awvalid, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_s_bvalid", s_bvalid, 0);
    chk("rst_s_arready", s_arready, 0);
    rst = 1'b0; #1;
    chk("post_rst_arready", s_arready, 1);
    chk("post_rst_awready", s_awready, 1);

    // Read 0x8000_0000, arlen=0 -> m0
    s_arvalid = 1; s_araddr = 32'h8000_0000; s_arid = 4'd2; s_arlen = 8'd0;
    cyc();
    s_arvalid = 0; #1;
    chk("rd0_m0_arvalid", m0_arvalid, 1);
    chk("rd0_m1_arvalid", m1_arvalid, 0);
    chk("rd0_m0_araddr", m0_araddr, 32'h8000_0000);
    chk("rd0_m0_arid", m0_arid, 2);
    chk("rd0_arready_busy", s_arready, 0);
    m0_arready = 1;
    cyc();
    m0_arready = 0;
    m0_rvalid = 1; m0_rdata = 32'hDEAD_BEEF; m0_rlast = 1; m0_rid = 4'd2; m0_rresp = 2'd0;
    s_rready = 1; #1;
    chk("rd0_m0_arvalid_drop", m0_arvalid, 0);
    chk("rd0_s_rvalid", s_rvalid, 1);
    chk("rd0_s_rdata", s_rdata, 32'hDEAD_BEEF);
    chk("rd0_s_rlast", s_rlast, 1);
    chk("rd0_s_rid", s_rid, 2);
    chk("rd0_m0_rready", m0_rready, 1);
    chk("rd0_m1_rready", m1_rready, 0);
    cyc();
    m0_rvalid = 0; m0_rlast = 0; s_rready = 0; #1;
    chk("rd0_arready_back", s_arready, 1);
    chk("rd0_rvalid_done", s_rvalid, 0);

    // Write 0x0200_BFF8 -> m1, W offered early must be held off
    s_awvalid = 1; s_awaddr = 32'h0200_BFF8; s_awid = 4'd7; s_awlen = 8'd0;
    s_wvalid = 1; s_wdata = 32'h0000_1234; s_wstrb = 4'hF; s_wlast = 1; #1;
    chk("wr1_early_wready", s_wready, 0);
    chk("wr1_early_m1_wvalid", m1_wvalid, 0);
    cyc();
    s_awvalid = 0; #1;
    chk("wr1_m1_awvalid", m1_awvalid, 1);
    chk("wr1_m0_awvalid", m0_awvalid, 0);
    chk("wr1_m1_awaddr", m1_awaddr, 32'h0200_BFF8);
    chk("wr1_m1_awid", m1_awid, 7);
    chk("wr1_addr_wready", s_wready, 0);
    m1_awready = 1;
    cyc();
    m1_awready = 0; m1_wready = 1; #1;
    chk("wr1_m1_wvalid", m1_wvalid, 1);
    chk("wr1_m0_wvalid", m0_wvalid, 0);
    chk("wr1_m1_wdata", m1_wdata, 32'h0000_1234);
    chk("wr1_m1_wstrb", m1_wstrb, 32'hF);
    chk("wr1_s_wready", s_wready, 1);
    cyc();
    s_wvalid = 0; s_wlast = 0; m1_wready = 0;
    m1_bvalid = 1; m1_bresp = 2'd0; m1_bid = 4'd7; s_bready = 1; #1;
    chk("wr1_s_bvalid", s_bvalid, 1);
    chk("wr1_s_bresp", s_bresp, 0);
    chk("wr1_s_bid", s_bid, 7);
    chk("wr1_m1_bready", m1_bready, 1);
    chk("wr1_m0_bready", m0_bready, 0);
    cyc();
    m1_bvalid = 0; s_bready = 0; #1;
    chk("wr1_awready_back", s_awready, 1);
    chk("wr1_bvalid_done", s_bvalid, 0);

    // Unmapped read 0x1000_0000, arlen=3, arid=5
    s_arvalid = 1; s_araddr = 32'h1000_0000; s_arid = 4'd5; s_arlen = 8'd3;
    cyc();
    s_arvalid = 0; #1;
`ifdef XBAR_DECERR_EN
    s_rready = 1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("err_rd_rvalid", s_rvalid, 1);
      chk("err_rd_rresp", s_rresp, 3);
      chk("err_rd_rid", s_rid, 5);
      chk("err_rd_rdata", s_rdata, 0);
      chk("err_rd_rlast", s_rlast, (b == 3) ? 1 : 0);
      chk("err_rd_no_arvalid", m0_arvalid | m1_arvalid, 0);
      cyc();
    end
    s_rready = 0; #1;
    chk("err_rd_rvalid_done", s_rvalid, 0);
    chk("err_rd_arready_back", s_arready, 1);
`else
    chk("nodec_rd_m0_arvalid", m0_arvalid, 1);
    chk("nodec_rd_m0_araddr", m0_araddr, 32'h1000_0000);
    chk("nodec_rd_m1_arvalid", m1_arvalid, 0);
    rst = 1; cyc(); rst = 0; #1;
`endif

    // Unmapped write of 2 beats
    s_awvalid = 1; s_awaddr = 32'h2000_0000; s_awid = 4'd3; s_awlen = 8'd1;
    cyc();
    s_awvalid = 0;
`ifdef XBAR_DECERR_EN
    s_wvalid = 1; s_wdata = 32'h0000_00AA; s_wlast = 0; #1;
    chk("err_wr_wready0", s_wready, 1);
    chk("err_wr_no_wvalid0", m0_wvalid | m1_wvalid, 0);
    chk("err_wr_no_awvalid", m0_awvalid | m1_awvalid, 0);
    cyc();
    s_wlast = 1; #1;
    chk("err_wr_wready1", s_wready, 1);
    chk("err_wr_no_wvalid1", m0_wvalid | m1_wvalid, 0);
    cyc();
    s_wvalid = 0; s_wlast = 0; s_bready = 1; #1;
    chk("err_wr_bvalid", s_bvalid, 1);
    chk("err_wr_bresp", s_bresp, 3);
    chk("err_wr_bid", s_bid, 3);
    cyc();
    s_bready = 0; #1;
    chk("err_wr_bvalid_done", s_bvalid, 0);
    chk("err_wr_awready_back", s_awready, 1);
`else
    #1;
    chk("nodec_wr_m0_awvalid", m0_awvalid, 1);
    chk("nodec_wr_m0_awaddr", m0_awaddr, 32'h2000_0000);
    chk("nodec_wr_m1_awvalid", m1_awvalid, 0);
    rst = 1; cyc(); rst = 0; #1;
`endif

    // Concurrent read to m1 (2 beats) and 4-beat write to m0, rready toggling
    s_arvalid = 1; s_araddr = 32'h0200_0004; s_arid = 4'd1; s_arlen = 8'd1;
    s_awvalid = 1; s_awaddr = 32'h8000_0100; s_awid = 4'd9; s_awlen = 8'd3;
    cyc();
    s_arvalid = 0; s_awvalid = 0; #1;
    chk("cc_m1_arvalid", m1_arvalid, 1);
    chk("cc_m0_awvalid", m0_awvalid, 1);
    chk("cc_m0_arvalid", m0_arvalid, 0);
    chk("cc_m1_awvalid", m1_awvalid, 0);
    m1_arready = 1; m0_awready = 1;
    cyc();
    m1_arready = 0; m0_awready = 0;
    rb = 0;
    for (int i = 0; i < 4; i++) begin
      s_rready  = (i % 2 == 0);
      m1_rvalid = (rb < 2);
      m1_rdata  = 32'hA0 + rb;
      m1_rlast  = (rb == 1);
      m1_rid    = 4'd1;
      s_wvalid  = 1; s_wdata = 32'hB0 + i; s_wstrb = 4'hF; s_wlast = (i == 3);
      m0_wready = 1;
      #1;
      chk("cc_s_rvalid", s_rvalid, (rb < 2) ? 1 : 0);
      if (rb < 2) begin
        chk("cc_s_rdata", s_rdata, 32'hA0 + rb);
        chk("cc_s_rlast", s_rlast, (rb == 1) ? 1 : 0);
        chk("cc_s_rid", s_rid, 1);
      end
      chk("cc_m1_rready", m1_rready, (rb < 2 && s_rready) ? 1 : 0);
      chk("cc_m0_wvalid", m0_wvalid, 1);
      chk("cc_m1_wvalid", m1_wvalid, 0);
      chk("cc_m0_wdata", m0_wdata, 32'hB0 + i);
      chk("cc_m0_wlast", m0_wlast, (i == 3) ? 1 : 0);
      chk("cc_s_wready", s_wready, 1);
      if (i == 3) chk("cc_arready_after_rd", s_arready, 1);
      cyc();
      if (s_rready && rb < 2) rb++;
    end
    s_wvalid = 0; s_wlast = 0; m0_wready = 0; m1_rvalid = 0; m1_rlast = 0; s_rready = 0;
    m0_bvalid = 1; m0_bresp = 2'd0; m0_bid = 4'd9; s_bready = 1; #1;
    chk("cc_s_bvalid", s_bvalid, 1);
    chk("cc_s_bid", s_bid, 9);
    chk("cc_s_bresp", s_bresp, 0);
    chk("cc_m0_bready", m0_bready, 1);
    cyc();
    m0_bvalid = 0; s_bready = 0; #1;
    chk("cc_awready_back", s_awready, 1);

    // Reset during R_DATA of an 8-beat read, then a fresh read
    s_arvalid = 1; s_araddr = 32'h8000_0040; s_arid = 4'd6; s_arlen = 8'd7;
    cyc();
    s_arvalid = 0; m0_arready = 1; #1;
    chk("rr_m0_arlen", m0_arlen, 7);
    cyc();
    m0_arready = 0; m0_rvalid = 1; m0_rdata = 32'h11; m0_rid = 4'd6; m0_rlast = 0;
    s_rready = 1; #1;
    chk("rr_s_rvalid_pre", s_rvalid, 1);
    cyc();
    rst = 1;
    cyc();
    chk("rr_s_rvalid_rst", s_rvalid, 0);
    chk("rr_m0_rready_rst", m0_rready, 0);
    rst = 0; m0_rvalid = 0; s_rready = 0; #1;
    chk("rr_arready_after", s_arready, 1);
    s_arvalid = 1; s_araddr = 32'h8000_0000; s_arid = 4'd4; s_arlen = 8'd0;
    cyc();
    s_arvalid = 0; #1;
    chk("rr2_m0_arvalid", m0_arvalid, 1);
    chk("rr2_m0_arid", m0_arid, 4);
    m0_arready = 1;
    cyc();
    m0_arready = 0; m0_rvalid = 1; m0_rdata = 32'h55; m0_rlast = 1; m0_rid = 4'd4;
    s_rready = 1; #1;
    chk("rr2_s_rdata", s_rdata, 32'h55);
    chk("rr2_s_rlast", s_rlast, 1);
    chk("rr2_s_rid", s_rid, 4);
    cyc();
    m0_rvalid = 0; m0_rlast = 0; s_rready = 0; #1;
    chk("rr2_arready_back", s_arready, 1);
    chk("rr2_rvalid_done", s_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
